// File: rtl/lsu.sv
// Load/store unit: turns execute-stage results into register writebacks and
// single outstanding data-memory transactions with lane steering and extension.
module lsu (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [2:0]  funct3,
  input  logic        mm_re,
  input  logic        mm_we,
  input  logic [31:0] mm_addr,
  input  logic [31:0] data,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_addr,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd_addr,
  output logic [31:0] wb_data,
  output logic        misaligned
);

  localparam int DATA_W = 32;

  typedef enum logic {IDLE, BUS} state_t;

  state_t state_p1, state_nxt;

  // Illegal size encodings fold into the misaligned path.
  function automatic logic access_ok(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b000, 3'b100: access_ok = 1'b1;
      3'b001, 3'b101: access_ok = ~off[0];
      3'b010:         access_ok = (off == 2'b00);
      default:        access_ok = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   store_be = 4'b0001 << off;
      2'b01:   store_be = off[1] ? 4'b1100 : 4'b0011;
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] store_lanes(input logic [2:0] f3,
                                                    input logic [DATA_W-1:0] sd);
    case (f3[1:0])
      2'b00:   store_lanes = {4{sd[7:0]}};
      2'b01:   store_lanes = {2{sd[15:0]}};
      default: store_lanes = sd;
    endcase
  endfunction

  // Shift the addressed lane down; funct3[2] selects zero- over sign-extension.
  function automatic logic [DATA_W-1:0] load_extend(input logic [2:0] f3,
                                                    input logic [1:0] off,
                                                    input logic [DATA_W-1:0] rdata);
    logic signed [7:0]  lane_b;
    logic signed [15:0] lane_h;
    case (off)
      2'd0:    lane_b = rdata[7:0];
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      default: lane_b = rdata[31:24];
    endcase
    lane_h = off[1] ? rdata[31:16] : rdata[15:0];
    case (f3[1:0])
      2'b00:   load_extend = f3[2] ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'b01:   load_extend = f3[2] ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_extend = rdata;
    endcase
  endfunction

  // ---- stage p0: decode of the presented op ----
  logic              accept_p0;
  logic              is_mem_p0;
  logic              ok_p0;
  logic              start_bus_p0;
  logic [3:0]        be_p0;
  logic [DATA_W-1:0] wdata_p0;

  assign accept_p0    = valid_in & ~stall;
  assign is_mem_p0    = mm_re | mm_we;
  assign ok_p0        = access_ok(funct3, mm_addr[1:0]);
  assign start_bus_p0 = accept_p0 & is_mem_p0 & ok_p0;
  assign be_p0        = mm_we ? store_be(funct3, mm_addr[1:0]) : 4'b1111;
  assign wdata_p0     = store_lanes(funct3, store_data);

  always_comb begin
    state_nxt = state_p1;
    case (state_p1)
      IDLE:    if (start_bus_p0) state_nxt = BUS;
      BUS:     if (dmem_ack)     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage p1: bus transaction and writeback registers ----
  logic              we_p1;
  logic [2:0]        funct3_p1;
  logic [1:0]        off_p1;
  logic [4:0]        rd_p1;
  logic              vld_p1;
  logic              mis_p1;
  logic              load_done_p1;

  assign load_done_p1 = (state_p1 == BUS) & dmem_ack & ~we_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_p1 <= IDLE;
      vld_p1   <= 1'b0;
      mis_p1   <= 1'b0;
      we_p1    <= 1'b0;
    end else begin
      state_p1 <= state_nxt;
      vld_p1   <= (accept_p0 & ~is_mem_p0) | load_done_p1;
      mis_p1   <= accept_p0 & is_mem_p0 & ~ok_p0;
      if (start_bus_p0) we_p1 <= mm_we;
    end
  end

  // Bus-facing and writeback values are architecturally visible, so they clear on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      wb_data    <= '0;
      wb_rd_addr <= '0;
    end else begin
      if (start_bus_p0) begin
        dmem_addr  <= {mm_addr[31:2], 2'b00};
        dmem_be    <= be_p0;
        dmem_wdata <= wdata_p0;
      end
      if (accept_p0 & ~is_mem_p0) begin
        wb_data    <= data;
        wb_rd_addr <= rd_addr;
      end else if (load_done_p1) begin
        wb_data    <= load_extend(funct3_p1, off_p1, dmem_rdata);
        wb_rd_addr <= rd_p1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start_bus_p0) begin
      funct3_p1 <= funct3;
      off_p1    <= mm_addr[1:0];
      rd_p1     <= rd_addr;
    end
  end

  assign stall      = (state_p1 == BUS);
  assign dmem_req   = (state_p1 == BUS);
  assign dmem_we    = (state_p1 == BUS) & we_p1;
  assign wb_valid   = vld_p1;
  assign misaligned = mis_p1;

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for the load/store unit.
module tb_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [2:0]  funct3;
  logic        mm_re, mm_we;
  logic [31:0] mm_addr, data, store_data;
  logic [4:0]  rd_addr;
  logic        stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_data;
  logic        misaligned;

  int n_cmp = 0;
  int n_err = 0;

  lsu dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .funct3(funct3),
    .mm_re(mm_re), .mm_we(mm_we), .mm_addr(mm_addr), .data(data),
    .store_data(store_data), .rd_addr(rd_addr), .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr),
    .wb_data(wb_data), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_in = 0; funct3 = 3'b000; mm_re = 0; mm_we = 0;
    mm_addr = 0; data = 0; store_data = 0; rd_addr = 0;
  endtask

  task automatic present(input logic re, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] rd);
    valid_in = 1; mm_re = re; mm_we = we; funct3 = f3;
    mm_addr = addr; store_data = sd; rd_addr = rd; data = 32'hDEAD_BEEF;
  endtask

  // Load with two wait cycles then ack; stall must be high for all three bus cycles.
  task automatic load_2wait(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] rdata, input logic [31:0] exp);
    present(1, 0, f3, addr, 0, 5'd7);
    tick();
    idle_inputs();
    chk({tag, "_stall_a"}, {31'b0, stall}, 32'd1);
    chk({tag, "_req"}, {31'b0, dmem_req}, 32'd1);
    chk({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
    chk({tag, "_be"}, {28'b0, dmem_be}, 32'hF);
    chk({tag, "_we"}, {31'b0, dmem_we}, 32'd0);
    tick();
    chk({tag, "_stall_b"}, {31'b0, stall}, 32'd1);
    chk({tag, "_wb_early"}, {31'b0, wb_valid}, 32'd0);
    tick();
    chk({tag, "_stall_c"}, {31'b0, stall}, 32'd1);
    dmem_ack = 1; dmem_rdata = rdata;
    tick();
    dmem_ack = 0; dmem_rdata = 0;
    chk({tag, "_wb_valid"}, {31'b0, wb_valid}, 32'd1);
    chk({tag, "_wb_data"}, wb_data, exp);
    chk({tag, "_wb_rd"}, {27'b0, wb_rd_addr}, 32'd7);
    chk({tag, "_stall_done"}, {31'b0, stall}, 32'd0);
    chk({tag, "_req_done"}, {31'b0, dmem_req}, 32'd0);
    tick();
    chk({tag, "_wb_pulse"}, {31'b0, wb_valid}, 32'd0);
  endtask

  initial begin
    idle_inputs();
    reset = 1; dmem_ack = 0; dmem_rdata = 0;
    tick(); tick();
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_req", {31'b0, dmem_req}, 32'd0);
    chk("rst_we", {31'b0, dmem_we}, 32'd0);
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_mis", {31'b0, misaligned}, 32'd0);
    chk("rst_be", {28'b0, dmem_be}, 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_rd", {27'b0, wb_rd_addr}, 32'd0);
    reset = 0;

    // Non-memory op writes back after one cycle.
    valid_in = 1; data = 32'h1234; rd_addr = 5'd5;
    tick();
    idle_inputs();
    chk("alu_wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("alu_wb_data", wb_data, 32'h1234);
    chk("alu_wb_rd", {27'b0, wb_rd_addr}, 32'd5);
    chk("alu_stall", {31'b0, stall}, 32'd0);
    tick();
    chk("alu_wb_pulse", {31'b0, wb_valid}, 32'd0);

    load_2wait("lb", 3'b000, 32'h103, 32'h80FF_FFFF, 32'hFFFF_FF80);
    load_2wait("lbu", 3'b100, 32'h103, 32'h80FF_FFFF, 32'h0000_0080);
    load_2wait("lh", 3'b001, 32'h102, 32'h8001_7FFF, 32'hFFFF_8001);
    load_2wait("lhu", 3'b101, 32'h102, 32'h8001_7FFF, 32'h0000_8001);
    load_2wait("lw", 3'b010, 32'h1F0, 32'hCAFE_F00D, 32'hCAFE_F00D);

    // SH to upper half.
    present(0, 1, 3'b001, 32'h202, 32'hABCD_1234, 5'd3);
    tick();
    idle_inputs();
    chk("sh_req", {31'b0, dmem_req}, 32'd1);
    chk("sh_we", {31'b0, dmem_we}, 32'd1);
    chk("sh_addr", dmem_addr, 32'h200);
    chk("sh_be", {28'b0, dmem_be}, 32'b1100);
    chk("sh_wdata", dmem_wdata, 32'h1234_1234);
    dmem_ack = 1;
    tick();
    dmem_ack = 0;
    chk("sh_no_wb", {31'b0, wb_valid}, 32'd0);
    chk("sh_stall_done", {31'b0, stall}, 32'd0);
    tick();
    chk("sh_no_wb2", {31'b0, wb_valid}, 32'd0);

    // re and we together is a store: SB at byte 1.
    present(1, 1, 3'b000, 32'h101, 32'h0000_005A, 5'd4);
    tick();
    idle_inputs();
    chk("sb_we", {31'b0, dmem_we}, 32'd1);
    chk("sb_be", {28'b0, dmem_be}, 32'b0010);
    chk("sb_wdata", dmem_wdata, 32'h5A5A_5A5A);
    dmem_ack = 1;
    tick();
    dmem_ack = 0;
    chk("sb_no_wb", {31'b0, wb_valid}, 32'd0);

    // Misaligned LW.
    present(1, 0, 3'b010, 32'h101, 0, 5'd9);
    tick();
    idle_inputs();
    chk("mis_lw_pulse", {31'b0, misaligned}, 32'd1);
    chk("mis_lw_req", {31'b0, dmem_req}, 32'd0);
    chk("mis_lw_wb", {31'b0, wb_valid}, 32'd0);
    chk("mis_lw_stall", {31'b0, stall}, 32'd0);
    tick();
    chk("mis_lw_clear", {31'b0, misaligned}, 32'd0);

    // Misaligned LH at odd address, and illegal funct3 at an aligned address.
    present(1, 0, 3'b001, 32'h103, 0, 5'd9);
    tick();
    chk("mis_lh_pulse", {31'b0, misaligned}, 32'd1);
    present(1, 0, 3'b011, 32'h100, 0, 5'd9);
    tick();
    idle_inputs();
    chk("mis_f3_pulse", {31'b0, misaligned}, 32'd1);
    chk("mis_f3_req", {31'b0, dmem_req}, 32'd0);
    tick();
    chk("mis_f3_clear", {31'b0, misaligned}, 32'd0);

    // Reset mid-BUS with simultaneous ack.
    present(1, 0, 3'b010, 32'h300, 0, 5'd11);
    tick();
    idle_inputs();
    chk("rbus_req_before", {31'b0, dmem_req}, 32'd1);
    reset = 1; dmem_ack = 1; dmem_rdata = 32'h5555_5555;
    tick();
    reset = 0; dmem_ack = 0; dmem_rdata = 0;
    chk("rbus_req", {31'b0, dmem_req}, 32'd0);
    chk("rbus_wb", {31'b0, wb_valid}, 32'd0);
    chk("rbus_stall", {31'b0, stall}, 32'd0);
    tick();
    chk("rbus_wb_after", {31'b0, wb_valid}, 32'd0);
    chk("rbus_idle", {31'b0, stall}, 32'd0);

    // Stray ack while idle, then back-to-back ALU ops (including rd=0).
    dmem_ack = 1; dmem_rdata = 32'h7777_7777;
    tick();
    chk("stray_wb", {31'b0, wb_valid}, 32'd0);
    chk("stray_stall", {31'b0, stall}, 32'd0);
    chk("stray_req", {31'b0, dmem_req}, 32'd0);
    valid_in = 1; data = 32'hA1; rd_addr = 5'd1;
    tick();
    chk("b2b0_valid", {31'b0, wb_valid}, 32'd1);
    chk("b2b0_data", wb_data, 32'hA1);
    data = 32'hB2; rd_addr = 5'd2;
    tick();
    chk("b2b1_valid", {31'b0, wb_valid}, 32'd1);
    chk("b2b1_data", wb_data, 32'hB2);
    chk("b2b1_rd", {27'b0, wb_rd_addr}, 32'd2);
    data = 32'hC3; rd_addr = 5'd0;
    tick();
    dmem_ack = 0; dmem_rdata = 0;
    idle_inputs();
    chk("b2b2_valid", {31'b0, wb_valid}, 32'd1);
    chk("b2b2_data", wb_data, 32'hC3);
    chk("b2b2_rd", {27'b0, wb_rd_addr}, 32'd0);
    tick();
    chk("b2b_end", {31'b0, wb_valid}, 32'd0);

    // Load with immediate ack, then a store accepted in the writeback cycle.
    present(1, 0, 3'b001, 32'h102, 0, 5'd12);
    tick();
    idle_inputs();
    dmem_ack = 1; dmem_rdata = 32'h8001_0000;
    tick();
    dmem_ack = 0; dmem_rdata = 0;
    chk("nb_wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("nb_wb_data", wb_data, 32'hFFFF_8001);
    chk("nb_stall", {31'b0, stall}, 32'd0);
    present(0, 1, 3'b010, 32'h400, 32'h0BAD_CAFE, 5'd13);
    tick();
    idle_inputs();
    chk("nb_st_req", {31'b0, dmem_req}, 32'd1);
    chk("nb_st_addr", dmem_addr, 32'h400);
    chk("nb_st_be", {28'b0, dmem_be}, 32'hF);
    chk("nb_st_wdata", dmem_wdata, 32'h0BAD_CAFE);
    chk("nb_st_wb", {31'b0, wb_valid}, 32'd0);
    dmem_ack = 1;
    tick();
    dmem_ack = 0;
    chk("nb_st_done", {31'b0, stall}, 32'd0);
    chk("nb_st_no_wb", {31'b0, wb_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-003 SHALL have port valid_in, input, 1 bit: the execute-stage result presented this cycle is valid.
REQ-004 SHALL have port funct3, input, 3 bits: access size and sign (000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU).
REQ-005 SHALL have ports mm_re and mm_we, input, 1 bit each: load request and store request.
REQ-006 SHALL have port mm_addr, input, 32 bits: byte address.
REQ-007 SHALL have port data, input, 32 bits: result to write back for non-memory operations.
REQ-008 SHALL have port store_data, input, 32 bits: rs2 value to store.
REQ-009 SHALL have port rd_addr, input, 5 bits: destination register.
REQ-010 SHALL have port stall, output, 1 bit: the unit cannot accept; upstream holds its inputs.
REQ-011 SHALL have ports dmem_req (output, 1), dmem_we (output, 1), dmem_addr (output, 32, word-aligned), dmem_be (output, 4), dmem_wdata (output, 32).
REQ-012 SHALL have ports dmem_ack (input, 1) and dmem_rdata (input, 32).
REQ-013 SHALL have ports wb_valid (output, 1), wb_rd_addr (output, 5), wb_data (output, 32).
REQ-014 SHALL have port misaligned, output, 1 bit: single-cycle error pulse.

Function
REQ-015 SHALL use FSM states IDLE and BUS; stall SHALL equal (state == BUS).
REQ-016 SHALL accept an input only in the cycle where valid_in=1 and stall=0.
REQ-017 An accepted non-memory op (mm_re=0, mm_we=0) SHALL drive wb_valid=1, wb_data=data and wb_rd_addr=rd_addr in the next cycle; latency is 1.
REQ-018 An accepted, aligned memory op SHALL enter BUS and register addr, be, wdata, we, funct3, rd_addr and addr[1:0].
REQ-019 In BUS, dmem_req SHALL be 1 and all dmem_* outputs SHALL stay stable until the cycle in which dmem_ack=1; the FSM returns to IDLE on the next edge.
REQ-020 dmem_addr SHALL equal {mm_addr[31:2], 2'b00}.
REQ-021 For stores, dmem_be SHALL be: byte 0001<<addr[1:0]; half 0011 (addr[1]=0) or 1100 (addr[1]=1); word 1111.
REQ-022 For stores, dmem_wdata SHALL be: SB the byte replicated 4x; SH the half replicated 2x; SW store_data.
REQ-023 For loads, dmem_be SHALL be 1111 and dmem_we SHALL be 0.
REQ-024 A load SHALL capture dmem_rdata on the ack cycle and drive wb_valid=1 in the following cycle, with the selected lane shifted down; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-025 A store SHALL never assert wb_valid.
REQ-026 When mm_we=1 and mm_re=1, the op SHALL be treated as a store.
REQ-027 A half access with addr[0]=1, or a word access with addr[1:0]!=0, SHALL pulse misaligned=1 the next cycle, issue no bus request, produce no writeback, and leave the FSM in IDLE.
REQ-028 funct3 values 011, 110 and 111 on a memory op SHALL be handled as misaligned.
REQ-029 dmem_ack received while not in BUS SHALL be ignored.
REQ-030 rd_addr=0 SHALL still produce wb_valid; x0 suppression is done by the register file.
REQ-031 wb_valid and misaligned SHALL be 1-cycle pulses per accepted op.
REQ-032 Back-to-back non-memory ops SHALL sustain one writeback per cycle.
REQ-033 A memory op accepted in the same cycle that a prior load writes back SHALL be accepted, with no bubble.
REQ-034 The minimum load latency SHALL be 3 cycles (accept, BUS with ack, writeback).

Reset
REQ-035 On reset, the FSM SHALL go to IDLE and stall, dmem_req, dmem_we, wb_valid and misaligned SHALL be 0; dmem_be, dmem_addr, dmem_wdata, wb_data and wb_rd_addr SHALL be 0.
REQ-036 Reset during BUS SHALL deassert dmem_req on the next edge and discard the pending op (no writeback).
REQ-037 Reset SHALL take priority over every simultaneous input, including dmem_ack.

Verification
REQ-038 Non-memory op, data=0x1234, rd=5 -> next cycle wb_valid=1, wb_data=0x1234, wb_rd_addr=5, stall=0.
REQ-039 LB at address 0x103 with ack after 2 wait cycles, rdata=0x80FF_FFFF -> dmem_addr=0x100, stall high 3 cycles, wb_data=0xFFFF_FF80; the same access as LBU -> 0x0000_0080.
REQ-040 SH at address 0x202 with store_data=0xABCD_1234 -> dmem_be=1100, dmem_wdata=0x1234_1234, dmem_we=1, no wb_valid.
REQ-041 LW at address 0x101 -> misaligned pulse, dmem_req stays 0, no wb_valid, stall=0.
REQ-042 Reset asserted mid-BUS with ack arriving in the same cycle -> dmem_req=0 after the edge, no wb_valid, FSM in IDLE.
REQ-043 Stray dmem_ack while IDLE, followed by back-to-back ALU ops -> the ack is ignored and one writeback is produced per cycle.
